// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the programmable sequence detector.
package seq_det_pkg;

  localparam int unsigned DEF_MAX_LEN     = 8;
  localparam int unsigned DEF_LEN_W       = 4;
  localparam logic [7:0]  DEF_PATTERN_C   = 8'h5A;
  localparam int unsigned DEF_LEN_C       = 7;
  localparam int unsigned DEF_OVL_C       = 1;
  localparam int unsigned DEF_CNT_W       = 16;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  // Lengths above the history depth are treated as the full depth.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register, fill counter and length-masked pattern compare.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned LEN_W   = DEF_LEN_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_shift,
  input  logic               i_seq_in,
  input  logic               i_clr,
  input  logic [LEN_W-1:0]   i_len,
  input  logic [MAX_LEN-1:0] i_pattern,
  output logic               o_hit_c,
  output logic               o_full_c
);

  logic [MAX_LEN-1:0] r_hist;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   w_fill_next;

  always_comb begin
    w_hist_next = r_hist;
    w_fill_next = r_fill;
    if (i_shift) begin
      w_hist_next = {r_hist[MAX_LEN-2:0], i_seq_in};
      if (r_fill < i_len) begin
        w_fill_next = r_fill + LEN_W'(1);
      end
    end
  end

  // Only the low len bits of history/pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      w_mask[i] = (i < int'(i_len));
    end
  end

  assign o_full_c = (i_len != '0) && (w_fill_next >= i_len);
  assign o_hit_c  = i_shift && o_full_c && (((w_hist_next ^ i_pattern) & w_mask) == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else begin
      if (i_shift) begin
        r_hist <= w_hist_next;
      end
      if (i_clr) begin
        r_fill <= '0;
      end else begin
        r_fill <= w_fill_next;
      end
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector: config registers, FILL/ARMED FSM, flag pulse.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned         MAX_LEN     = DEF_MAX_LEN,
  parameter int unsigned         LEN_W       = DEF_LEN_W,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int unsigned         DEF_LEN     = DEF_LEN_C,
  parameter int unsigned         DEF_OVL     = DEF_OVL_C,
  parameter int unsigned         CNT_W       = DEF_CNT_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_seq_valid,
  input  logic               i_seq_in,
  input  logic               i_cfg_we,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  output logic               o_flag,
  output logic               o_armed,
  output logic [CNT_W-1:0]   o_match_cnt
);

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  state_e             r_state;
  logic               r_flag;

  logic               w_shift;
  logic               w_clr;
  logic               w_hit;
  logic               w_full;
  logic [LEN_W-1:0]   w_len_ld;

  // A config write takes priority and swallows any bit offered in the same cycle.
  assign w_shift  = i_seq_valid && !i_cfg_we;
  assign w_clr    = i_cfg_we || (w_hit && !r_ovl);
  assign w_len_ld = LEN_W'(clamp_len(32'(i_cfg_len), MAX_LEN));

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_shift   (w_shift),
    .i_seq_in  (i_seq_in),
    .i_clr     (w_clr),
    .i_len     (r_len),
    .i_pattern (r_pattern),
    .o_hit_c   (w_hit),
    .o_full_c  (w_full)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pattern <= DEF_PATTERN;
      r_len     <= LEN_W'(DEF_LEN);
      r_ovl     <= (DEF_OVL != 0);
      r_state   <= ST_FILL;
      r_flag    <= 1'b0;
    end else begin
      r_flag <= w_hit;
      if (i_cfg_we) begin
        r_pattern <= i_cfg_pattern;
        r_len     <= w_len_ld;
        r_ovl     <= i_cfg_overlap;
        r_state   <= ST_FILL;
      end else if (w_shift) begin
        // Non-overlapping hits restart collection; overlapping hits keep history live.
        if (w_hit && !r_ovl) begin
          r_state <= ST_FILL;
        end else if (w_full) begin
          r_state <= ST_ARMED;
        end
      end
    end
  end

  assign o_flag  = r_flag;
  assign o_armed = (r_state == ST_ARMED);

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_cfg_we) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_match_cnt = r_cnt;
`else
  assign o_match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Table-driven bench for seq_det_prog with a scoreboard queue of expected outputs.
module tb_seq_det_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 16;

  logic               clk;
  logic               rst;
  logic               seq_valid;
  logic               seq_in;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               flag;
  logic               armed;
  logic [CNT_W-1:0]   match_cnt;

  seq_det_prog #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_seq_valid   (seq_valid),
    .i_seq_in      (seq_in),
    .i_cfg_we      (cfg_we),
    .i_cfg_pattern (cfg_pattern),
    .i_cfg_len     (cfg_len),
    .i_cfg_overlap (cfg_overlap),
    .o_flag        (flag),
    .o_armed       (armed),
    .o_match_cnt   (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               cfg;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic               v;
    logic               b;
    logic               ef;
    logic               ea;
  } step_t;

  typedef struct {
    logic             flag;
    logic             armed;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  step_t tbl[$];
  exp_t  sbq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bit string: '1'/'0' valid bits, '_' an idle cycle; flag/armed strings give expectations.
  function automatic void add_stream(input string b, input string f, input string a);
    step_t s;
    for (int i = 0; i < b.len(); i++) begin
      s.cfg = 1'b0; s.pat = '0; s.len = '0; s.ovl = 1'b0;
      s.v   = (b.getc(i) != "_");
      s.b   = (b.getc(i) == "1");
      s.ef  = (f.getc(i) == "1");
      s.ea  = (a.getc(i) == "1");
      tbl.push_back(s);
    end
  endfunction

  function automatic void add_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                                  input logic ovl, input logic v, input logic b);
    step_t s;
    s.cfg = 1'b1; s.pat = pat; s.len = len; s.ovl = ovl;
    s.v = v; s.b = b; s.ef = 1'b0; s.ea = 1'b0;
    tbl.push_back(s);
  endfunction

  task automatic apply(input step_t s, input string tag);
    exp_t e;
    exp_t got;
    cfg_we      = s.cfg;
    cfg_pattern = s.pat;
    cfg_len     = s.len;
    cfg_overlap = s.ovl;
    seq_valid   = s.v;
    seq_in      = s.b;
    if (s.cfg) exp_cnt = 0;
    else if (s.ef) exp_cnt++;
    e.flag  = s.ef;
    e.armed = s.ea;
`ifdef SEQ_DET_CNT_EN
    e.cnt   = CNT_W'(exp_cnt);
`else
    e.cnt   = '0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    chk({tag, ".flag"},  32'(flag),      32'(got.flag));
    chk({tag, ".armed"}, 32'(armed),     32'(got.armed));
    chk({tag, ".cnt"},   32'(match_cnt), 32'(got.cnt));
  endtask

  task automatic run_phase(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("%s[%0d]", name, i));
    end
    tbl.delete();
    cfg_we    = 1'b0;
    seq_valid = 1'b0;
    seq_in    = 1'b0;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic rst_pulse(input string name);
    rst = 1'b1;
    #2;
    chk({name, ".flag"},  32'(flag),      32'd0);
    chk({name, ".armed"}, 32'(armed),     32'd0);
    chk({name, ".cnt"},   32'(match_cnt), 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; seq_valid = 1'b0; seq_in = 1'b0;
    cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.flag",  32'(flag),      32'd0);
    chk("reset.armed", 32'(armed),     32'd0);
    chk("reset.cnt",   32'(match_cnt), 32'd0);
    rst = 1'b0;
    #1;

    // Default 1011010 overlapping: second match reuses the trailing "10".
    add_stream("1011010", "0000001", "0000001");
    add_stream("_",       "0",       "1");
    add_stream("11010",   "00001",   "11111");
    run_phase("dflt");

    // Reset after six bits loses the partial match; fresh fill needed.
    rst_pulse("rst_a");
    add_stream("101101", "000000", "000000");
    run_phase("pre_rst");
    rst_pulse("rst_b");
    add_stream("0",       "0",       "0");
    add_stream("1011010", "0000001", "0000011");
    run_phase("post_rst");

    // Idle gaps between valid bits are transparent.
    rst_pulse("rst_c");
    add_stream("1_0__11_01_0_", "0000000000010", "0000000000011");
    run_phase("gaps");

    // 101, len 3, non-overlapping: each match needs three fresh bits.
    add_cfg(8'h05, 4'd3, 1'b0, 1'b0, 1'b0);
    add_stream("1010101", "0010001", "0000010");
    run_phase("novl");

    // 101, len 3, overlapping.
    add_cfg(8'h05, 4'd3, 1'b1, 1'b0, 1'b0);
    add_stream("10101", "00101", "00111");
    run_phase("ovl");

    // Config together with a valid bit: the bit is dropped, so "01" cannot complete 101.
    add_cfg(8'h05, 4'd3, 1'b1, 1'b1, 1'b1);
    add_stream("010", "000", "001");
    run_phase("cfg_drop");

    // Zero length disables detection entirely.
    add_cfg(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    add_stream("10110101011010", "00000000000000", "00000000000000");
    run_phase("len0");

    // Length 12 clamps to 8.
    add_cfg(8'hA5, 4'd12, 1'b1, 1'b0, 1'b0);
    add_stream("10100101", "00000001", "00000001");
    add_stream("00101",    "00001",    "11111");
    run_phase("clamp");

    chk("sb.empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
